fmul_core: RTL
==============

# fmul_core

Sequential magnitude multiplier for the single-precision float multiply path. It takes two 31-bit unsigned float magnitudes (8-bit exponent, 23-bit fraction; the sign is handled separately), multiplies the mantissas with a 24-cycle shift-add loop, and adds the exponents. It then normalizes, truncates, and clamps the result. Its registered `product` drives the `in` port of the downstream special-case judge stage. That stage overrides the result for zero/INF/NaN operands, so this block does not special-case them.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  31  operand A magnitude: [30:23] exponent, [22:0] fraction.
- `b`  in  31  operand B magnitude, same format.
- `product`  out  31  registered result magnitude; holds its value until the next `done`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle onward.

## Operation
- States: IDLE, MUL, NORM.
- IDLE with `start`=1 at edge T0:
  - latch the mantissas `ma={ea!=0, a[22:0]}` and `mb={eb!=0, b[22:0]}` (hidden bit is 1 only for a nonzero exponent);
  - latch the exponent sum `es = {2'b0,ea} + {2'b0,eb} - 10'd127` (10-bit signed, range -127..383);
  - clear the 48-bit accumulator; count=0; go to MUL.
- MUL, one step per edge T1..T24:
  - if multiplier bit[count]=1, add `ma << count` to the accumulator;
  - count++;
  - after count reaches 23 (the 24th step), go to NORM.
  - The count is 5 bits and never wraps past 23.
- NORM, edge T25. Compute `p`=accumulator:
  - if p[47]=1: frac=p[46:24], e=es+1;
  - else: frac=p[45:23], e=es.
  - Truncate; no rounding.
- Clamp:
  - if e ≥ 255: product=31'h7F800000 (INF magnitude);
  - else if e ≤ 0, or p[47:46]==2'b00 (zero/denormal mantissa): product=0;
  - else product={e[7:0], frac}.
  - Then done=1 and return to IDLE.
- `start` while busy is ignored, and the operands are not re-sampled.
- Zero, INF and NaN operands produce a defined but meaningless value. The downstream judge stage overrides it.

## Timing
- Reset values: `product`=0, `done`=0, `busy`=0, state IDLE, accumulator=0, count=0.
- Latency: `start` accepted at edge T0, `done` asserted after edge T25, so the result is 25 clocks after acceptance.
- `busy`:
  - goes to 1 after T0 and to 0 after T25, in the same cycle that `done` rises;
  - `busy` and `done` are never high together.
- `done` is high for exactly one cycle.
- `start`=1 in the `done` cycle is accepted at the next edge, giving back-to-back operation every 26 cycles.
- `a`/`b` may change any time after T0 with no effect on the current result.
- `rst_n` low at any time, including mid-MUL or at T25:
  - all outputs return to reset values immediately (asynchronously);
  - the operation is discarded and no `done` is issued;
  - after release, the block waits in IDLE for a new `start`.
- `product` changes only at T25 or at reset.

## Test plan
- a=0x3FC00000 (1.5), b=0x40000000 (2.0), start one cycle -> `done` exactly 25 cycles later, product=0x40400000, `busy` high for cycles 1..25.
- a=0x3FC00000, b=0x3FC00000 (1.5×1.5, exercises the p[47] path) -> product=0x40100000; a=b=0x3F800000 -> product=0x3F800000.
- a=0x7F000000, b=0x40000000 -> product=0x7F800000 (overflow clamp); a=b=0x00800000 -> product=0x00000000 (underflow flush).
- Start with a=0x40400000, b=0x40400000 (3×3), then pulse `start` with new operands at cycles 5 and 20 -> both ignored, product=0x41100000; `start` held in the `done` cycle -> second `done` 26 cycles after the first.
- Assert `rst_n`=0 at cycle 12 of an operation -> product/busy/done=0 immediately, no `done` after release, product stays 0 until a new start completes.

Source files
------------

// File: rtl/fmul_core_if.sv
`default_nettype none
// ============================================================================
// Module      : fmul_core_if
// Description : Request/result bundle for the sequential float magnitude
//               multiplier. The requester (master) drives start/a/b and
//               observes product/busy/done; the multiplier core is the slave.
// Ports       : start   - request, sampled by the core only while idle
//               a, b    - 31-bit magnitudes: [30:23] exponent, [22:0] fraction
//               product - registered result magnitude
//               busy    - operation in flight
//               done    - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface fmul_core_if;
  logic        start;
  logic [30:0] a;
  logic [30:0] b;
  logic [30:0] product;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output a,
    output b,
    input  product,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output product,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/fmul_core.sv
`default_nettype none
// ============================================================================
// Module      : fmul_core
// Description : Sequential magnitude multiplier for the single-precision
//               multiply path. 24-step shift-add mantissa multiply, exponent
//               add, then normalize / truncate / clamp. Zero, INF and NaN
//               operands are not special-cased; the downstream judge stage
//               overrides the result for those.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - fmul_core_if.slave (start, a, b, product, busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_core (
  input  wire logic   clk,
  input  wire logic   rst_n,
  fmul_core_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2
  } state_t;

  localparam logic [4:0]  c_LAST_STEP = 5'd23;
  localparam logic [30:0] c_INF_MAG   = 31'h7F80_0000;

  state_t             r_state;
  state_t             w_state_next;
  logic [23:0]        r_ma;
  logic [23:0]        r_mb;
  logic signed [9:0]  r_es;
  logic [47:0]        r_acc;
  logic [4:0]         r_count;
  logic [30:0]        r_product;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic               w_finish;

  // Operand decode (only consumed on the accepting edge)
  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic [9:0]         w_es_sum;

  // Shift-add step
  logic [23:0]        w_mb_shifted;
  logic [47:0]        w_addend;

  // Normalization
  logic signed [9:0]  w_e;
  logic [22:0]        w_frac;
  logic [30:0]        w_result;

  assign w_ea     = bus.a[30:23];
  assign w_eb     = bus.b[30:23];
  // Biased exponent sum minus one bias; modulo-1024 arithmetic, read as
  // signed it covers -127..383 without overflow.
  assign w_es_sum = {2'b00, w_ea} + {2'b00, w_eb} - 10'd127;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        w_step = 1'b1;
        if (r_count == c_LAST_STEP) begin
          w_state_next = S_NORM;
        end
      end
      S_NORM: begin
        w_finish     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath combinational terms
  // --------------------------------------------------------------------------
  always_comb begin
    // Multiplier bit selected by the step counter (count stays 0..23)
    w_mb_shifted = r_mb >> r_count;
    w_addend     = w_mb_shifted[0] ? ({24'd0, r_ma} << r_count) : 48'd0;

    // Product of two 1.x mantissas lies in [1,4): bit 47 set means >= 2.0,
    // so take one bit higher and bump the exponent.
    if (r_acc[47]) begin
      w_frac = r_acc[46:24];
      w_e    = r_es + 10'sd1;
    end else begin
      w_frac = r_acc[45:23];
      w_e    = r_es;
    end

    // Overflow wins over the zero/denormal flush.
    if (w_e >= 10'sd255) begin
      w_result = c_INF_MAG;
    end else if ((w_e <= 10'sd0) || (r_acc[47:46] == 2'b00)) begin
      w_result = 31'd0;
    end else begin
      w_result = {w_e[7:0], w_frac};
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ma      <= 24'd0;
      r_mb      <= 24'd0;
      r_es      <= 10'sd0;
      r_acc     <= 48'd0;
      r_count   <= 5'd0;
      r_product <= 31'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        // Hidden bit present only for a nonzero exponent
        r_ma    <= {(w_ea != 8'd0), bus.a[22:0]};
        r_mb    <= {(w_eb != 8'd0), bus.b[22:0]};
        r_es    <= $signed(w_es_sum);
        r_acc   <= 48'd0;
        r_count <= 5'd0;
      end else if (w_step) begin
        r_acc <= r_acc + w_addend;
        if (r_count != c_LAST_STEP) begin
          r_count <= r_count + 5'd1;
        end
      end
      if (w_finish) begin
        r_product <= w_result;
      end
    end
  end

  assign bus.product = r_product;
  assign bus.done    = r_done;
  // Busy drops on the same edge that raises done, so the two never overlap.
  assign bus.busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire
